// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM and its clear engine.
package sp_ram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int RDW_WRITE_FIRST = 32'sd0;
  localparam int RDW_READ_FIRST  = 32'sd1;

  function automatic int byte_lanes(input int data_width);
    return data_width / 32'sd8;
  endfunction

endpackage

// File: rtl/sp_ram_clr_fsm.sv
// Post-reset clear engine: walks every word address once while BUSY is high
// so the top can mux an all-zero write into the array port.
module sp_ram_clr_fsm
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int CLR_ON_RST = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_clr_adr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;

  // Clear FSM; a reset in the middle of a clear restarts it from address 0.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
      if (CLR_ON_RST != 0) begin
        r_state <= CLEAR;
        r_busy  <= 1'b1;
      end else begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_cnt == LAST_ADR) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_clr_adr = r_cnt;

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, optional output register and post-reset zero fill.
module sp_ram_param
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    EN,
  input  logic                    WRE,
  input  logic [DATA_WIDTH/8-1:0] BE,
  input  logic [ADDR_WIDTH-1:0]   ADR,
  input  logic [DATA_WIDTH-1:0]   D,
  output logic [DATA_WIDTH-1:0]   Q,
  output logic                    VALID,
  output logic                    BUSY
);

  localparam int NB = byte_lanes(DATA_WIDTH);

  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_clr_adr;
  logic                  w_in_range;
  logic                  w_access;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_adr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [NB-1:0]         w_wr_be;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q1;
  logic                  r_v1;

  sp_ram_clr_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_fsm (
    .i_clk     (CLK),
    .i_rstn    (RSTN),
    .o_busy    (w_busy),
    .o_clr_adr (w_clr_adr)
  );

  // Access decode, clear/user write mux and read-during-write data selection.
  always_comb begin
    w_in_range = ({1'b0, ADR} < (ADDR_WIDTH + 1)'(DEPTH));
    w_access   = RSTN && EN && !w_busy;
    if (w_in_range) begin
      w_old = r_mem[ADR];
    end else begin
      w_old = '0;
    end
    w_merged = w_old;
    for (int k = 0; k < NB; k++) begin
      if (BE[k]) begin
        w_merged[8*k +: 8] = D[8*k +: 8];
      end else begin
        w_merged[8*k +: 8] = w_old[8*k +: 8];
      end
    end
    if (!w_in_range) begin
      w_rd_data = '0;
    end else if (WRE && (RDW_MODE == RDW_WRITE_FIRST)) begin
      w_rd_data = w_merged;
    end else begin
      w_rd_data = w_old;
    end
    // Reset never touches the array, so the clear write is gated by RSTN too.
    if (RSTN && w_busy) begin
      w_wr_en   = 1'b1;
      w_wr_adr  = w_clr_adr;
      w_wr_data = '0;
      w_wr_be   = '1;
    end else begin
      w_wr_en   = w_access && WRE && w_in_range;
      w_wr_adr  = ADR;
      w_wr_data = D;
      w_wr_be   = BE;
    end
  end

  // Storage array, no reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (w_wr_be[k]) begin
          r_mem[w_wr_adr][8*k +: 8] <= w_wr_data[8*k +: 8];
        end
      end
    end
  end

  // First read stage: Q holds whenever no access is issued.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_q1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_access;
      if (w_access) begin
        r_q1 <= w_rd_data;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_q2;
    logic                  r_v2;

    // Optional second output stage.
    always_ff @(posedge CLK) begin
      if (!RSTN) begin
        r_q2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_q2 <= r_q1;
        end
      end
    end

    assign Q     = r_q2;
    assign VALID = r_v2;
  end else begin : g_no_out_reg
    assign Q     = r_q1;
    assign VALID = r_v1;
  end

  assign BUSY = w_busy;

endmodule
